// File: rtl/keycode_mapper.sv
// -----------------------------------------------------------------------------
// keycode_mapper
//
// Turns PS/2 scan-code-set-2 bytes from the keyboard receiver into the packed
// keycode bus read by the tank state logic. Each byte of the bus carries one
// action group. The parser follows the E0 (extended) and F0 (break) prefixes.
// A held-key map records which mapped keys are down. Each group reports the
// value of its most recently pressed key. When that key is released, the group
// falls back to the lowest value among its keys that are still held.
//
// Ports
//   Clk         in   1   system clock, single domain
//   Reset_n     in   1   asynchronous active-low reset
//   scan_code   in   8   received PS/2 byte
//   scan_valid  in   1   one-cycle strobe qualifying scan_code; always accepted
//   keycode     out  32  [31:24] tank1 base, [23:16] tank1 turret,
//                        [15:8] tank2 base, [7:0] tank2 turret
//   key_event   out  1   one-cycle pulse in the cycle keycode takes a new value
//   held_keys   out  14  [3:0] W,A,S,D  [6:4] J,K,Space
//                        [10:7] Up,Left,Down,Right  [13:11] KP1,KP2,KP0
//
// Optional build macro
//   KEYMAP_TIMEOUT_EN  builds an idle counter. If no byte arrives for
//                      TIMEOUT_CYCLES cycles, the counter clears every held
//                      key, every group and the parser. This recovers from a
//                      break code that was lost on the wire.
// -----------------------------------------------------------------------------
module keycode_mapper #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned TIMEOUT_W      = 26
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    output logic [31:0] keycode,
    output logic        key_event,
    output logic [13:0] held_keys
);

    localparam int unsigned NKEYS = 14;

    // The idle counter must be able to represent TIMEOUT_CYCLES.
    if (64'(TIMEOUT_CYCLES) >= (64'd1 << TIMEOUT_W)) begin : g_bad_timeout_w
        $error("keycode_mapper: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        EXTBRK = 2'd3
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;   // bit position in held_keys
    } key_t;

    // Code -> held-map bit. 72 is shared: Down when E0-prefixed, KP2 otherwise.
    function automatic key_t decode(input logic [7:0] code, input logic ext);
        key_t k;
        k.hit = 1'b1;
        k.idx = 4'd0;
        if (!ext) begin
            case (code)
                8'h1D:   k.idx = 4'd0;   // W
                8'h1C:   k.idx = 4'd1;   // A
                8'h1B:   k.idx = 4'd2;   // S
                8'h23:   k.idx = 4'd3;   // D
                8'h3B:   k.idx = 4'd4;   // J
                8'h42:   k.idx = 4'd5;   // K
                8'h29:   k.idx = 4'd6;   // Space
                8'h69:   k.idx = 4'd11;  // KP1
                8'h72:   k.idx = 4'd12;  // KP2
                8'h70:   k.idx = 4'd13;  // KP0
                default: k.hit = 1'b0;
            endcase
        end else begin
            case (code)
                8'h75:   k.idx = 4'd7;   // Up
                8'h6B:   k.idx = 4'd8;   // Left
                8'h72:   k.idx = 4'd9;   // Down
                8'h74:   k.idx = 4'd10;  // Right
                default: k.hit = 1'b0;
            endcase
        end
        return k;
    endfunction

    // Byte lane of keycode that a held-map bit belongs to.
    function automatic logic [1:0] key_group(input logic [3:0] idx);
        logic [1:0] g;
        if (idx <= 4'd3)       g = 2'd3;
        else if (idx <= 4'd6)  g = 2'd2;
        else if (idx <= 4'd10) g = 2'd1;
        else                   g = 2'd0;
        return g;
    endfunction

    // Action value a key drives onto its group lane.
    function automatic logic [7:0] key_value(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd0:    v = 8'd3;  // W
            4'd1:    v = 8'd1;  // A
            4'd2:    v = 8'd2;  // S
            4'd3:    v = 8'd4;  // D
            4'd4:    v = 8'd1;  // J
            4'd5:    v = 8'd2;  // K
            4'd6:    v = 8'd3;  // Space
            4'd7:    v = 8'd3;  // Up
            4'd8:    v = 8'd1;  // Left
            4'd9:    v = 8'd2;  // Down
            4'd10:   v = 8'd4;  // Right
            4'd11:   v = 8'd1;  // KP1
            4'd12:   v = 8'd2;  // KP2
            4'd13:   v = 8'd3;  // KP0
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // Lowest nonzero value among the held keys of one group, or 0 if none are held.
    function automatic logic [7:0] fallback_value(input logic [13:0] held, input logic [1:0] grp);
        logic [7:0] best;
        logic [7:0] v;
        best = 8'd0;
        for (int i = 0; i < NKEYS; i++) begin
            v = key_value(4'(i));
            if (held[i] && (key_group(4'(i)) == grp) && ((best == 8'd0) || (v < best))) begin
                best = v;
            end
        end
        return best;
    endfunction

    state_e      state_q, state_d;
    logic [13:0] held_q, held_d;
    logic [31:0] keycode_q, keycode_d;
    logic        key_event_q, key_event_d;

    key_t        key;
    logic [1:0]  grp;
    logic [4:0]  lsb;
    logic [7:0]  val;
    logic        do_make;
    logic        do_break;
    logic        do_clear;
    logic        expire;

`ifdef KEYMAP_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] idle_q, idle_d;

    // Expiry is the single cycle in which the counter steps onto TIMEOUT_CYCLES.
    // A byte arriving in that cycle takes priority, so expiry is suppressed.
    always_comb begin
        expire = 1'b0;
        idle_d = idle_q;
        if (scan_valid) begin
            idle_d = '0;
        end else if (idle_q != TIMEOUT_W'(TIMEOUT_CYCLES)) begin
            idle_d = idle_q + 1'b1;
            expire = (idle_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        keycode_d = keycode_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        do_clear = 1'b0;

        key = decode(scan_code, (state_q == EXT) || (state_q == EXTBRK));
        grp = key_group(key.idx);
        lsb = {grp, 3'b000};
        val = key_value(key.idx);

        if (scan_valid) begin
            case (state_q)
                IDLE: begin
                    if (scan_code == 8'hE0)      state_d = EXT;
                    else if (scan_code == 8'hF0) state_d = BRK;
                    else if (scan_code == 8'hAA) do_clear = 1'b1;
                    else if (key.hit)            do_make = 1'b1;
                end
                EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_d = EXTBRK;
                    end else begin
                        state_d = IDLE;
                        do_make = key.hit;
                    end
                end
                BRK, EXTBRK: begin
                    state_d  = IDLE;
                    do_break = key.hit;
                end
                default: state_d = IDLE;
            endcase
        end

        // AA is the keyboard's self-test-passed code. It arrives after a
        // keyboard reset, so any held state from before that reset is stale.
        if (do_clear) begin
            held_d    = '0;
            keycode_d = '0;
        end

        // A repeated make (typematic) rewrites the lane. This lets a held key
        // reclaim its group after another key in the group took over.
        if (do_make) begin
            held_d[key.idx]     = 1'b1;
            keycode_d[lsb +: 8] = val;
        end

        // Keys in one group have distinct values. A lane equal to this key's
        // value therefore means this key is the active key of the group.
        if (do_break && held_q[key.idx]) begin
            held_d[key.idx] = 1'b0;
            if (keycode_q[lsb +: 8] == val) begin
                keycode_d[lsb +: 8] = fallback_value(held_d, grp);
            end
        end

        if (expire) begin
            state_d   = IDLE;
            held_d    = '0;
            keycode_d = '0;
        end

        key_event_d = (keycode_d != keycode_q);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            held_q      <= '0;
            keycode_q   <= '0;
            key_event_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            keycode_q   <= keycode_d;
            key_event_q <= key_event_d;
        end
    end

    assign keycode   = keycode_q;
    assign key_event = key_event_q;
    assign held_keys = held_q;

endmodule

// File: tb/tb_keycode_mapper.sv
module tb_keycode_mapper;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic [31:0] keycode;
    logic        key_event;
    logic [13:0] held_keys;

    int n_checks = 0;
    int n_pass   = 0;

    keycode_mapper #(.TIMEOUT_CYCLES(100), .TIMEOUT_W(8)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .keycode    (keycode),
        .key_event  (key_event),
        .held_keys  (held_keys)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    logic [7:0]  m_grp [4];      // lane value, index = byte lane of keycode
    logic [13:0] m_held;
    bit          m_ext, m_brk;   // prefixes seen so far in the current sequence
    logic [31:0] m_prev;

    logic [7:0] pool [0:12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h3B, 8'h42, 8'h29,
                                8'h69, 8'h72, 8'h70, 8'h75, 8'h6B, 8'h74};

    function automatic int key_of(bit ext, logic [7:0] c);
        if (!ext) begin
            case (c)
                8'h1D: return 0;  8'h1C: return 1;  8'h1B: return 2;  8'h23: return 3;
                8'h3B: return 4;  8'h42: return 5;  8'h29: return 6;
                8'h69: return 11; 8'h72: return 12; 8'h70: return 13;
                default: return -1;
            endcase
        end
        case (c)
            8'h75: return 7; 8'h6B: return 8; 8'h72: return 9; 8'h74: return 10;
            default: return -1;
        endcase
    endfunction

    function automatic int grp_of(int k);
        if (k < 4) return 3;      // tank1 base
        if (k < 7) return 2;      // tank1 turret
        if (k < 11) return 1;     // tank2 base
        return 0;                 // tank2 turret
    endfunction

    function automatic int val_of(int k);
        int vals [14] = '{3, 1, 2, 4, 1, 2, 3, 3, 1, 2, 4, 1, 2, 3};
        return vals[k];
    endfunction

    function automatic logic [31:0] m_kc();
        return {m_grp[3], m_grp[2], m_grp[1], m_grp[0]};
    endfunction

    function automatic void model_reset();
        for (int g = 0; g < 4; g++) m_grp[g] = 8'd0;
        m_held = '0;
        m_ext  = 0;
        m_brk  = 0;
    endfunction

    function automatic void model_make(int k);
        m_held[k] = 1'b1;
        m_grp[grp_of(k)] = 8'(val_of(k));
    endfunction

    function automatic void model_break(int k);
        int g;
        if (!m_held[k]) return;
        m_held[k] = 1'b0;
        g = grp_of(k);
        if (m_grp[g] != 8'(val_of(k))) return;
        m_grp[g] = 8'd0;
        // Scan values high to low so the lowest held value is written last.
        for (int v = 4; v >= 1; v--)
            for (int j = 0; j < 14; j++)
                if (m_held[j] && grp_of(j) == g && val_of(j) == v) m_grp[g] = 8'(v);
    endfunction

    function automatic void model_byte(logic [7:0] c);
        int k;
        if (m_brk) begin
            k = key_of(m_ext, c);
            if (k >= 0) model_break(k);
            m_ext = 0;
            m_brk = 0;
        end else if (m_ext) begin
            if (c == 8'hF0) m_brk = 1;
            else begin
                k = key_of(1, c);
                if (k >= 0) model_make(k);
                m_ext = 0;
            end
        end else begin
            if (c == 8'hE0) m_ext = 1;
            else if (c == 8'hF0) m_brk = 1;
            else if (c == 8'hAA) begin
                m_held = '0;
                for (int g = 0; g < 4; g++) m_grp[g] = 8'd0;
            end else begin
                k = key_of(0, c);
                if (k >= 0) model_make(k);
            end
        end
    endfunction

    // Drives one byte for one cycle. Returns at the falling edge after the capturing edge.
    task automatic drive_byte(input logic [7:0] c);
        @(negedge Clk);
        m_prev     = m_kc();
        scan_code  = c;
        scan_valid = 1'b1;
        model_byte(c);
        @(negedge Clk);
        scan_valid = 1'b0;
        scan_code  = 8'($urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset_n = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
        model_reset();
        repeat (3) @(negedge Clk);
        n_checks++; if (keycode !== 32'h0) $display("FAIL reset_keycode got=%h exp=%h", keycode, 32'h0); else n_pass++;
        n_checks++; if (held_keys !== 14'h0) $display("FAIL reset_held got=%h exp=%h", held_keys, 14'h0); else n_pass++;
        n_checks++; if (key_event !== 1'b0) $display("FAIL reset_event got=%b exp=0", key_event); else n_pass++;
        Reset_n = 1'b1;
        @(negedge Clk);
        n_checks++; if (keycode !== 32'h0) $display("FAIL post_reset_keycode got=%h exp=%h", keycode, 32'h0); else n_pass++;
    endtask

    task automatic test_make_break();
        drive_byte(8'h1D);
        n_checks++; if (keycode !== 32'h0300_0000) $display("FAIL mk_W got=%h exp=%h", keycode, 32'h0300_0000); else n_pass++;
        n_checks++; if (key_event !== 1'b1) $display("FAIL mk_W_event got=%b exp=1", key_event); else n_pass++;
        n_checks++; if (held_keys !== 14'h0001) $display("FAIL mk_W_held got=%h exp=%h", held_keys, 14'h0001); else n_pass++;
        @(negedge Clk);
        n_checks++; if (key_event !== 1'b0) $display("FAIL mk_W_pulse_len got=%b exp=0", key_event); else n_pass++;
        drive_byte(8'hF0);
        n_checks++; if (key_event !== 1'b0 || keycode !== 32'h0300_0000)
            $display("FAIL brk_prefix got=%h/%b exp=%h/0", keycode, key_event, 32'h0300_0000); else n_pass++;
        drive_byte(8'h1D);
        n_checks++; if (keycode !== 32'h0) $display("FAIL brk_W got=%h exp=%h", keycode, 32'h0); else n_pass++;
        n_checks++; if (key_event !== 1'b1) $display("FAIL brk_W_event got=%b exp=1", key_event); else n_pass++;
    endtask

    task automatic test_fallback();
        drive_byte(8'h1C); drive_byte(8'h23);
        n_checks++; if (keycode[31:24] !== 8'h04) $display("FAIL fb_D got=%h exp=04", keycode[31:24]); else n_pass++;
        drive_byte(8'hF0); drive_byte(8'h23);
        n_checks++; if (keycode[31:24] !== 8'h01) $display("FAIL fb_to_A got=%h exp=01", keycode[31:24]); else n_pass++;
        n_checks++; if (key_event !== 1'b1) $display("FAIL fb_to_A_event got=%b exp=1", key_event); else n_pass++;
        drive_byte(8'hF0); drive_byte(8'h1C);
        n_checks++; if (keycode !== 32'h0 || held_keys !== 14'h0)
            $display("FAIL fb_release got=%h/%h exp=0/0", keycode, held_keys); else n_pass++;
    endtask

    task automatic test_nonactive_break();
        drive_byte(8'h1C); drive_byte(8'h23);          // A then D: D active
        drive_byte(8'hF0); drive_byte(8'h1C);          // break non-active A
        n_checks++; if (keycode !== 32'h0400_0000 || key_event !== 1'b0)
            $display("FAIL nonactive_brk got=%h/%b exp=%h/0", keycode, key_event, 32'h0400_0000); else n_pass++;
        drive_byte(8'hF0); drive_byte(8'h1C);          // A is no longer held
        n_checks++; if (held_keys !== 14'h0008 || key_event !== 1'b0)
            $display("FAIL unheld_brk got=%h/%b exp=%h/0", held_keys, key_event, 14'h0008); else n_pass++;
        drive_byte(8'h1C);                             // repeated make takes the lane back
        n_checks++; if (keycode !== 32'h0100_0000) $display("FAIL remake_A got=%h exp=%h", keycode, 32'h0100_0000); else n_pass++;
        drive_byte(8'hF0); drive_byte(8'h1C);
        n_checks++; if (keycode !== 32'h0400_0000) $display("FAIL fb_to_D got=%h exp=%h", keycode, 32'h0400_0000); else n_pass++;
        drive_byte(8'hF0); drive_byte(8'h23);
    endtask

    task automatic test_shared_72();
        drive_byte(8'hE0); drive_byte(8'h72);
        n_checks++; if (keycode !== 32'h0000_0200) $display("FAIL down got=%h exp=%h", keycode, 32'h0000_0200); else n_pass++;
        drive_byte(8'h72);
        n_checks++; if (keycode !== 32'h0000_0202) $display("FAIL kp2 got=%h exp=%h", keycode, 32'h0000_0202); else n_pass++;
        drive_byte(8'hE0); drive_byte(8'hF0); drive_byte(8'h72);
        n_checks++; if (keycode !== 32'h0000_0002) $display("FAIL down_brk got=%h exp=%h", keycode, 32'h0000_0002); else n_pass++;
        n_checks++; if (held_keys !== 14'h1000) $display("FAIL kp2_held got=%h exp=%h", held_keys, 14'h1000); else n_pass++;
        drive_byte(8'h75);                             // unprefixed Up code is unmapped
        n_checks++; if (keycode !== 32'h0000_0002 || held_keys !== 14'h1000)
            $display("FAIL unmapped_75 got=%h/%h exp=%h/%h", keycode, held_keys, 32'h0000_0002, 14'h1000); else n_pass++;
        drive_byte(8'hF0); drive_byte(8'h72);
    endtask

    task automatic test_reset_midseq();
        drive_byte(8'h29);
        drive_byte(8'hE0);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        n_checks++; if (keycode !== 32'h0 || held_keys !== 14'h0)
            $display("FAIL async_reset got=%h/%h exp=0/0", keycode, held_keys); else n_pass++;
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        drive_byte(8'h72);
        n_checks++; if (keycode !== 32'h0000_0002) $display("FAIL prefix_lost got=%h exp=%h", keycode, 32'h0000_0002); else n_pass++;
        drive_byte(8'hF0); drive_byte(8'h72);
    endtask

    task automatic test_aa_clear();
        drive_byte(8'h1D); drive_byte(8'h3B); drive_byte(8'hE0); drive_byte(8'h74); drive_byte(8'h70);
        n_checks++; if (keycode !== 32'h0301_0403) $display("FAIL four_groups got=%h exp=%h", keycode, 32'h0301_0403); else n_pass++;
        drive_byte(8'hAA);
        n_checks++; if (keycode !== 32'h0 || held_keys !== 14'h0 || key_event !== 1'b1)
            $display("FAIL aa_clear got=%h/%h/%b exp=0/0/1", keycode, held_keys, key_event); else n_pass++;
    endtask

    task automatic test_timeout();
        bit bad;
        drive_byte(8'h29);
        n_checks++; if (keycode !== 32'h0003_0000) $display("FAIL to_space got=%h exp=%h", keycode, 32'h0003_0000); else n_pass++;
`ifdef KEYMAP_TIMEOUT_EN
        bad = 0;
        for (int i = 1; i < 100; i++) begin
            @(negedge Clk);
            if (keycode !== 32'h0003_0000 || key_event !== 1'b0) bad = 1;
        end
        n_checks++; if (bad) $display("FAIL to_early got=%h exp=%h", keycode, 32'h0003_0000); else n_pass++;
        @(negedge Clk);
        n_checks++; if (keycode !== 32'h0 || held_keys !== 14'h0 || key_event !== 1'b1)
            $display("FAIL to_expire got=%h/%h/%b exp=0/0/1", keycode, held_keys, key_event); else n_pass++;
        @(negedge Clk);
        n_checks++; if (key_event !== 1'b0) $display("FAIL to_pulse_len got=%b exp=0", key_event); else n_pass++;
        model_reset();
`else
        bad = 0;
        repeat (150) begin
            @(negedge Clk);
            if (keycode !== 32'h0003_0000 || key_event !== 1'b0) bad = 1;
        end
        n_checks++; if (bad) $display("FAIL no_timeout got=%h exp=%h", keycode, 32'h0003_0000); else n_pass++;
        drive_byte(8'hF0); drive_byte(8'h29);
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [12] = '{8'hE0, 8'h75, 8'h1B, 8'hF0, 8'h1B, 8'h42,
                                 8'hE0, 8'hF0, 8'h75, 8'h69, 8'hF0, 8'h42};
        @(negedge Clk);
        for (int i = 0; i < 12; i++) begin
            m_prev     = m_kc();
            scan_code  = seq[i];
            scan_valid = 1'b1;
            model_byte(seq[i]);
            @(negedge Clk);
            n_checks++;
            if (keycode !== m_kc() || held_keys !== m_held || key_event !== (m_kc() != m_prev))
                $display("FAIL b2b_%0d got=%h/%h/%b exp=%h/%h/%b", i, keycode, held_keys, key_event,
                         m_kc(), m_held, (m_kc() != m_prev));
            else n_pass++;
        end
        scan_valid = 1'b0;
    endtask

    task automatic test_random();
        int r;
        logic [7:0] c;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 18)      c = 8'hE0;
            else if (r < 36) c = 8'hF0;
            else if (r < 38) c = 8'hAA;
            else if (r < 93) c = pool[$urandom_range(0, 12)];
            else             c = 8'($urandom);
            drive_byte(c);
            n_checks++;
            if (keycode !== m_kc() || held_keys !== m_held || key_event !== (m_kc() != m_prev))
                $display("FAIL rand_%0d code=%h got=%h/%h/%b exp=%h/%h/%b", i, c, keycode, held_keys,
                         key_event, m_kc(), m_held, (m_kc() != m_prev));
            else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_fallback();
        test_nonactive_break();
        test_shared_72();
        test_reset_midseq();
        test_aa_clear();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
